rv_dmem_arb: RTL and testbench
==============================

Name: rv_dmem_arb

Overview:
- Arbitrates the single data-memory port (rv_dmem_wrap) between the core LSU and a secondary debug/loader requester.
- Sits between the Q103H memory stage and rv_dmem_wrap. The core request path is combinational in Q103H.
- Read data returns one cycle later (Q104H) and is routed to the owner of the access by a registered tag.
- The core has fixed priority. The debug side uses a valid/ready handshake, gets a one-cycle-latency response, and has an address range check.

Parameters:
MEM_SIZE_BYTES, 64, size of the backing memory; a debug address >= this value returns an error.
STARVE_LIMIT, 8, consecutive blocked debug cycles before a forced debug grant (only with the optional feature).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
core_addr_Q103H  in  32  core byte address
core_wr_data_Q103H  in  32  core store data, LSB-aligned
core_wr_en_Q103H  in  1  core store
core_rd_en_Q103H  in  1  core load
core_byte_en_Q103H  in  4  core byte enables (0001/0011/1111)
core_is_signed_Q103H  in  1  core load sign-extend
core_stall_Q103H  out  1  core must hold its Q103H request
core_rd_data_Q104H  out  32  core load data
dbg_req_valid  in  1  debug request valid
dbg_req_ready  out  1  debug request accepted this cycle
dbg_req_addr  in  32  debug byte address
dbg_req_wr  in  1  1 = write, 0 = read
dbg_req_wr_data  in  32  debug write data
dbg_req_byte_en  in  4  debug byte enables
dbg_rsp_valid  out  1  one-cycle response pulse
dbg_rsp_rd_data  out  32  debug read data (zero for writes and errors)
dbg_rsp_err  out  1  out-of-range request
mem_addr_Q103H, mem_wr_data_Q103H  out  32 each  to rv_dmem_wrap
mem_wr_en_Q103H, mem_is_signed_Q103H  out  1 each  to rv_dmem_wrap
mem_byte_en_Q103H  out  4  to rv_dmem_wrap
mem_rd_data_Q104H  in  32  from rv_dmem_wrap

Behaviour:
- Clocking: single clock clk; rst is asynchronous and active-high.
- Reset values: all registered state is cleared.
  - dbg_rsp_valid=0, dbg_rsp_err=0, dbg_rsp_rd_data=0.
  - Owner tag = NONE, starvation counter = 0, core_stall_Q103H=0.
- Core request: core_req = core_rd_en_Q103H | core_wr_en_Q103H.
- Grant (combinational, Q103H):
  - Core is granted if core_req=1 and no forced debug grant is active.
  - Otherwise the debug side is granted if dbg_req_valid=1.
  - dbg_req_ready=1 exactly in cycles where the debug side is granted. A request is accepted when valid & ready.
- Mux:
  - The granted requester drives the mem_* signals.
  - A debug access drives mem_is_signed_Q103H=0 and mem_wr_en_Q103H=dbg_req_wr.
  - An idle cycle drives mem_wr_en_Q103H=0 and all other mem_* outputs to 0.
- Range check:
  - An accepted debug request with dbg_req_addr >= MEM_SIZE_BYTES is consumed, but mem_wr_en_Q103H is held at 0.
  - Its response has dbg_rsp_err=1 and dbg_rsp_rd_data=0.
- Owner tag (register, Q103H->Q104H), one of:
  - CORE (core access issued)
  - DBG (valid debug access)
  - DBG_ERR (out-of-range debug access)
  - NONE
- Q104H routing:
  - core_rd_data_Q104H = mem_rd_data_Q104H when tag=CORE, else 0.
  - dbg_rsp_valid=1 for exactly one cycle when tag is DBG or DBG_ERR. This applies to both reads and writes.
  - dbg_rsp_rd_data = mem_rd_data_Q104H for a DBG read, 0 for a DBG write.
- Back-to-back debug requests can be accepted every cycle. Responses return in order, one cycle after each acceptance.
- Simultaneous core and debug requests: the core wins and debug is held (dbg_req_ready=0). The debug request must stay stable while valid.
- Reset mid-operation: a pending Q104H response is dropped, with no dbg_rsp_valid after reset.
- Without the optional feature, core_stall_Q103H is constant 0.

Optional Feature:
- Macro: RV_DMEM_ARB_STARVE_EN.
- With the macro:
  - A counter increments each cycle in which dbg_req_valid=1 and dbg_req_ready=0.
  - The counter resets on debug acceptance or when dbg_req_valid=0.
  - When the counter reaches STARVE_LIMIT, the next cycle forces a debug grant, asserts core_stall_Q103H=1 for that one cycle, and clears the counter. The stalled core request is not issued to memory and is re-presented next cycle.
- Without the macro: no counter is built, core_stall_Q103H=0, and the core is never preempted.

Test Plan:
1. Core write addr=0, data=F0F0F0F0, be=1111, then core read addr=0 -> core_rd_data_Q104H=F0F0F0F0 one cycle after the read; dbg_rsp_valid stays 0.
2. Idle core; debug write addr=8, data=AAAAAAAA, then debug read addr=8 -> dbg_req_ready=1 on both requests; rsp pulses 1 cycle later with rd_data 0 then AAAAAAAA, err=0.
3. Core read addr=8 and debug read addr=4 valid in the same cycle -> core granted (dbg_req_ready=0); debug accepted the following cycle once the core goes idle; each data returns to its correct owner.
4. Debug read addr=64 (MEM_SIZE_BYTES=64) -> accepted, mem_wr_en=0, next cycle dbg_rsp_valid=1, err=1, rd_data=0.
5. rst asserted the cycle after debug read acceptance -> no dbg_rsp_valid; all outputs 0 while rst=1.
6. With RV_DMEM_ARB_STARVE_EN and STARVE_LIMIT=8: continuous core loads plus debug valid -> debug granted on cycle 9 with core_stall_Q103H=1 for one cycle. Without the macro, debug is never granted.

Source files
------------

// File: rtl/rv_dmem_arb.sv
// Data-memory port arbiter: the core LSU has fixed priority over a valid/ready debug requester.
// Define RV_DMEM_ARB_STARVE_EN to build the starvation counter that forces a debug grant.
module rv_dmem_arb #(
  parameter int MEM_SIZE_BYTES = 64,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] core_addr_Q103H,
  input  logic [31:0] core_wr_data_Q103H,
  input  logic        core_wr_en_Q103H,
  input  logic        core_rd_en_Q103H,
  input  logic [3:0]  core_byte_en_Q103H,
  input  logic        core_is_signed_Q103H,
  output logic        core_stall_Q103H,
  output logic [31:0] core_rd_data_Q104H,
  input  logic        dbg_req_valid,
  output logic        dbg_req_ready,
  input  logic [31:0] dbg_req_addr,
  input  logic        dbg_req_wr,
  input  logic [31:0] dbg_req_wr_data,
  input  logic [3:0]  dbg_req_byte_en,
  output logic        dbg_rsp_valid,
  output logic [31:0] dbg_rsp_rd_data,
  output logic        dbg_rsp_err,
  output logic [31:0] mem_addr_Q103H,
  output logic [31:0] mem_wr_data_Q103H,
  output logic        mem_wr_en_Q103H,
  output logic        mem_is_signed_Q103H,
  output logic [3:0]  mem_byte_en_Q103H,
  input  logic [31:0] mem_rd_data_Q104H
);
  typedef enum logic [1:0] {TAG_NONE, TAG_CORE, TAG_DBG, TAG_DBG_ERR} tag_e;

  logic w_core_req, w_force, w_core_gnt, w_dbg_gnt, w_dbg_oor;
  tag_e r_tag;
  logic r_dbg_wr;

  assign w_core_req = core_rd_en_Q103H | core_wr_en_Q103H;

`ifdef RV_DMEM_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] r_starve_cnt;

  // Counter only reaches the limit while debug is still waiting, so the force cycle clears it.
  assign w_force          = dbg_req_valid & (r_starve_cnt == CW'(STARVE_LIMIT));
  assign core_stall_Q103H = w_force;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_starve_cnt <= '0;
    else if (!dbg_req_valid || w_dbg_gnt) r_starve_cnt <= '0;
    else                                  r_starve_cnt <= r_starve_cnt + 1'b1;
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg     = ^STARVE_LIMIT;
  assign w_force          = 1'b0;
  assign core_stall_Q103H = 1'b0;
`endif

  // Grants are masked during reset so every output reads as idle while rst is high.
  assign w_core_gnt    = ~rst & w_core_req & ~w_force;
  assign w_dbg_gnt     = ~rst & dbg_req_valid & ~w_core_gnt;
  assign dbg_req_ready = w_dbg_gnt;
  assign w_dbg_oor     = dbg_req_addr >= 32'(MEM_SIZE_BYTES);

  always_comb begin
    mem_addr_Q103H      = '0;
    mem_wr_data_Q103H   = '0;
    mem_wr_en_Q103H     = 1'b0;
    mem_is_signed_Q103H = 1'b0;
    mem_byte_en_Q103H   = '0;
    if (w_core_gnt) begin
      mem_addr_Q103H      = core_addr_Q103H;
      mem_wr_data_Q103H   = core_wr_data_Q103H;
      mem_wr_en_Q103H     = core_wr_en_Q103H;
      mem_is_signed_Q103H = core_is_signed_Q103H;
      mem_byte_en_Q103H   = core_byte_en_Q103H;
    end else if (w_dbg_gnt) begin
      mem_addr_Q103H    = dbg_req_addr;
      mem_wr_data_Q103H = dbg_req_wr_data;
      mem_wr_en_Q103H   = dbg_req_wr & ~w_dbg_oor;
      mem_byte_en_Q103H = dbg_req_byte_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag    <= TAG_NONE;
      r_dbg_wr <= 1'b0;
    end else begin
      r_dbg_wr <= dbg_req_wr;
      if (w_core_gnt)     r_tag <= TAG_CORE;
      else if (w_dbg_gnt) r_tag <= w_dbg_oor ? TAG_DBG_ERR : TAG_DBG;
      else                r_tag <= TAG_NONE;
    end
  end

  assign core_rd_data_Q104H = (r_tag == TAG_CORE) ? mem_rd_data_Q104H : 32'd0;
  assign dbg_rsp_valid      = (r_tag == TAG_DBG) | (r_tag == TAG_DBG_ERR);
  assign dbg_rsp_err        = (r_tag == TAG_DBG_ERR);
  assign dbg_rsp_rd_data    = (r_tag == TAG_DBG && !r_dbg_wr) ? mem_rd_data_Q104H : 32'd0;
endmodule

// File: tb/tb_rv_dmem_arb.sv
// Directed bench for rv_dmem_arb: combinational grant/mux table plus multi-cycle sequences
// against a small one-cycle-latency word memory model.
module tb_rv_dmem_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] core_addr, core_wdata;
  logic        core_wr, core_rd, core_sg;
  logic [3:0]  core_be;
  logic        core_stall;
  logic [31:0] core_rdata;
  logic        dv, drdy, dwr;
  logic [31:0] daddr, dwdata;
  logic [3:0]  dbe;
  logic        rsp_v, rsp_err;
  logic [31:0] rsp_data;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_wen, m_sg;
  logic [3:0]  m_be;

  int n_tests = 0;
  int n_fail  = 0;

  rv_dmem_arb #(.MEM_SIZE_BYTES(64), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .core_addr_Q103H(core_addr), .core_wr_data_Q103H(core_wdata),
    .core_wr_en_Q103H(core_wr), .core_rd_en_Q103H(core_rd),
    .core_byte_en_Q103H(core_be), .core_is_signed_Q103H(core_sg),
    .core_stall_Q103H(core_stall), .core_rd_data_Q104H(core_rdata),
    .dbg_req_valid(dv), .dbg_req_ready(drdy), .dbg_req_addr(daddr),
    .dbg_req_wr(dwr), .dbg_req_wr_data(dwdata), .dbg_req_byte_en(dbe),
    .dbg_rsp_valid(rsp_v), .dbg_rsp_rd_data(rsp_data), .dbg_rsp_err(rsp_err),
    .mem_addr_Q103H(m_addr), .mem_wr_data_Q103H(m_wdata), .mem_wr_en_Q103H(m_wen),
    .mem_is_signed_Q103H(m_sg), .mem_byte_en_Q103H(m_be), .mem_rd_data_Q104H(m_rdata)
  );

  always #5 clk = ~clk;

  // Backing memory: 16 words, read data one cycle after the Q103H request.
  logic [31:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 32'd0;
  always @(posedge clk) begin
    if (m_wen)
      for (int b = 0; b < 4; b++)
        if (m_be[b]) mem[m_addr[5:2]][8*b +: 8] <= m_wdata[8*b +: 8];
    m_rdata <= mem[m_addr[5:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_rd = 0; core_wr = 0; core_addr = 0; core_wdata = 0; core_be = 0; core_sg = 0;
    dv = 0; dwr = 0; daddr = 0; dwdata = 0; dbe = 0;
  endtask

  typedef struct {
    logic crd, cwr, csg; logic [31:0] caddr, cdata; logic [3:0] cbe;
    logic dv, dwr; logic [31:0] daddr, ddata; logic [3:0] dbe;
    logic e_rdy, e_wen, e_sg; logic [31:0] e_addr, e_wdata; logic [3:0] e_be;
  } vec_t;
  vec_t vt[8];

  int grant_cyc, n_grant, n_stall;

  initial begin
    //          crd cwr csg caddr          cdata          cbe   dv dwr daddr          ddata          dbe    rdy wen sg addr          wdata          be
    vt[0] = '{0, 0, 1, 32'h100,       32'h55,        4'hF, 0, 0, 32'h0,        32'h0,         4'h0,  0, 0, 0, 32'h0,        32'h0,         4'h0};
    vt[1] = '{1, 0, 1, 32'h10,        32'h11,        4'h1, 0, 0, 32'h0,        32'h0,         4'h0,  0, 0, 1, 32'h10,       32'h11,        4'h1};
    vt[2] = '{0, 1, 0, 32'h22,        32'hBEEF,      4'h3, 0, 0, 32'h0,        32'h0,         4'h0,  0, 1, 0, 32'h22,       32'hBEEF,      4'h3};
    vt[3] = '{1, 0, 0, 32'h4,         32'h0,         4'hF, 1, 1, 32'h8,        32'h99,        4'hF,  0, 0, 0, 32'h4,        32'h0,         4'hF};
    vt[4] = '{0, 0, 1, 32'h0,         32'h0,         4'h0, 1, 1, 32'h3F,       32'h77,        4'h1,  1, 1, 0, 32'h3F,       32'h77,        4'h1};
    vt[5] = '{0, 0, 0, 32'h0,         32'h0,         4'h0, 1, 1, 32'h40,       32'h66,        4'hF,  1, 0, 0, 32'h40,       32'h66,        4'hF};
    vt[6] = '{0, 0, 0, 32'h0,         32'h0,         4'h0, 1, 0, 32'hFFFFFFFC, 32'h0,         4'hF,  1, 0, 0, 32'hFFFFFFFC, 32'h0,         4'hF};
    vt[7] = '{0, 0, 0, 32'h0,         32'h0,         4'h0, 1, 0, 32'h20,       32'h5,         4'hF,  1, 0, 0, 32'h20,       32'h5,         4'hF};

    idle();
    rst = 1;
    #12;
    chk("reset rsp_valid", {31'd0, rsp_v}, 32'd0);
    chk("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("reset rsp_data", rsp_data, 32'd0);
    chk("reset core_stall", {31'd0, core_stall}, 32'd0);
    chk("reset core_rdata", core_rdata, 32'd0);
    @(negedge clk); rst = 0;
    tick();

    // Combinational grant/mux table, one vector per cycle.
    for (int i = 0; i < 8; i++) begin
      core_rd = vt[i].crd; core_wr = vt[i].cwr; core_sg = vt[i].csg;
      core_addr = vt[i].caddr; core_wdata = vt[i].cdata; core_be = vt[i].cbe;
      dv = vt[i].dv; dwr = vt[i].dwr; daddr = vt[i].daddr; dwdata = vt[i].ddata; dbe = vt[i].dbe;
      #1;
      chk($sformatf("vec%0d ready", i), {31'd0, drdy}, {31'd0, vt[i].e_rdy});
      chk($sformatf("vec%0d wen", i), {31'd0, m_wen}, {31'd0, vt[i].e_wen});
      chk($sformatf("vec%0d signed", i), {31'd0, m_sg}, {31'd0, vt[i].e_sg});
      chk($sformatf("vec%0d addr", i), m_addr, vt[i].e_addr);
      chk($sformatf("vec%0d wdata", i), m_wdata, vt[i].e_wdata);
      chk($sformatf("vec%0d be", i), {28'd0, m_be}, {28'd0, vt[i].e_be});
      chk($sformatf("vec%0d stall", i), {31'd0, core_stall}, 32'd0);
      tick();
    end
    idle();
    tick();
    tick();

    // 1: core write then core read of word 0.
    core_wr = 1; core_addr = 0; core_wdata = 32'hF0F0F0F0; core_be = 4'hF;
    tick();
    chk("t1 no rsp after write", {31'd0, rsp_v}, 32'd0);
    core_wr = 0; core_rd = 1;
    tick();
    chk("t1 core read data", core_rdata, 32'hF0F0F0F0);
    chk("t1 no rsp after read", {31'd0, rsp_v}, 32'd0);
    idle();

    // 2: debug write then read of addr 8.
    dv = 1; dwr = 1; daddr = 8; dwdata = 32'hAAAAAAAA; dbe = 4'hF;
    #1 chk("t2 wr ready", {31'd0, drdy}, 32'd1);
    tick();
    chk("t2 wr rsp_valid", {31'd0, rsp_v}, 32'd1);
    chk("t2 wr rsp_data", rsp_data, 32'd0);
    chk("t2 wr rsp_err", {31'd0, rsp_err}, 32'd0);
    dwr = 0; dwdata = 0;
    #1 chk("t2 rd ready", {31'd0, drdy}, 32'd1);
    tick();
    chk("t2 rd rsp_valid", {31'd0, rsp_v}, 32'd1);
    chk("t2 rd rsp_data", rsp_data, 32'hAAAAAAAA);
    chk("t2 rd rsp_err", {31'd0, rsp_err}, 32'd0);
    idle();
    tick();
    chk("t2 rsp single pulse", {31'd0, rsp_v}, 32'd0);

    // 3: core and debug collide; core wins, debug follows.
    core_wr = 1; core_addr = 4; core_wdata = 32'h12345678; core_be = 4'hF;
    tick();
    core_wr = 0; core_rd = 1; core_addr = 8;
    dv = 1; dwr = 0; daddr = 4; dbe = 4'hF;
    #1;
    chk("t3 dbg held", {31'd0, drdy}, 32'd0);
    chk("t3 mem addr core", m_addr, 32'd8);
    tick();
    chk("t3 core data", core_rdata, 32'hAAAAAAAA);
    chk("t3 no dbg rsp yet", {31'd0, rsp_v}, 32'd0);
    core_rd = 0; core_addr = 0;
    #1;
    chk("t3 dbg ready", {31'd0, drdy}, 32'd1);
    chk("t3 mem addr dbg", m_addr, 32'd4);
    tick();
    chk("t3 dbg rsp_valid", {31'd0, rsp_v}, 32'd1);
    chk("t3 dbg data", rsp_data, 32'h12345678);
    chk("t3 core data idle", core_rdata, 32'd0);
    idle();

    // 4: out-of-range debug write and read at addr 64.
    dv = 1; dwr = 1; daddr = 64; dwdata = 32'hFFFFFFFF; dbe = 4'hF;
    #1;
    chk("t4 oor wr ready", {31'd0, drdy}, 32'd1);
    chk("t4 oor wr wen", {31'd0, m_wen}, 32'd0);
    tick();
    chk("t4 oor wr rsp_valid", {31'd0, rsp_v}, 32'd1);
    chk("t4 oor wr err", {31'd0, rsp_err}, 32'd1);
    dwr = 0; dwdata = 0;
    #1 chk("t4 oor rd wen", {31'd0, m_wen}, 32'd0);
    tick();
    chk("t4 oor rd rsp_valid", {31'd0, rsp_v}, 32'd1);
    chk("t4 oor rd err", {31'd0, rsp_err}, 32'd1);
    chk("t4 oor rd data", rsp_data, 32'd0);
    idle();
    core_rd = 1; core_addr = 0;
    tick();
    chk("t4 word0 untouched", core_rdata, 32'hF0F0F0F0);
    idle();
    tick();

    // 5: reset right after a debug read acceptance drops the response.
    dv = 1; dwr = 0; daddr = 8; dbe = 4'hF;
    tick();
    rst = 1; core_rd = 1; core_addr = 4;
    #1;
    chk("t5 rst rsp_valid", {31'd0, rsp_v}, 32'd0);
    chk("t5 rst rsp_data", rsp_data, 32'd0);
    chk("t5 rst ready", {31'd0, drdy}, 32'd0);
    chk("t5 rst mem addr", m_addr, 32'd0);
    chk("t5 rst mem wen", {31'd0, m_wen}, 32'd0);
    chk("t5 rst core_rdata", core_rdata, 32'd0);
    tick();
    chk("t5 rst held rsp_valid", {31'd0, rsp_v}, 32'd0);
    idle();
    rst = 0;
    tick();
    chk("t5 after rst rsp_valid", {31'd0, rsp_v}, 32'd0);

    // 6: continuous core loads against a waiting debug read.
    grant_cyc = 0; n_grant = 0; n_stall = 0;
    core_rd = 1; core_addr = 0; core_be = 4'hF;
    dv = 1; dwr = 0; daddr = 12; dbe = 4'hF;
    for (int c = 1; c <= 12; c++) begin
      #1;
      if (drdy) begin
        n_grant++;
        if (grant_cyc == 0) grant_cyc = c;
      end
      if (core_stall) n_stall++;
      if (c == 9) begin
`ifdef RV_DMEM_ARB_STARVE_EN
        chk("t6 forced addr", m_addr, 32'd12);
        chk("t6 forced stall", {31'd0, core_stall}, 32'd1);
`else
        chk("t6 core keeps port", m_addr, 32'd0);
`endif
      end
      tick();
    end
`ifdef RV_DMEM_ARB_STARVE_EN
    chk("t6 grant cycle", grant_cyc, 32'd9);
    chk("t6 grant count", n_grant, 32'd1);
    chk("t6 stall count", n_stall, 32'd1);
`else
    chk("t6 grant count", n_grant, 32'd0);
    chk("t6 stall count", n_stall, 32'd0);
`endif
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
